// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state codes,
// opcode values and the fixed pattern shown on the display in ERR.
package calc_pkg;

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_SHOW   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam logic [15:0] ERR_DISP = 16'hEEEE;

endpackage

// File: rtl/btn_sync_edge.sv
// Brings a raw push-button into the clock domain and turns each
// press into a single-cycle pulse, however long the button is held.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain plus one delayed copy of its output for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/calc_sequencer.sv
// Top-level control FSM of the 8-bit calculator: collects operand A,
// operand B and the opcode from the switches, runs the external ALU
// through a start/done handshake, keeps the result and picks what the
// display shows.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int RES_W       = 16,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_done,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] b_reg,
  output logic [1:0]        op_reg,
  output logic              alu_start,
  output logic [RES_W-1:0]  result_reg,
  output logic [RES_W-1:0]  disp_value,
  output logic [2:0]        state_out,
  output logic              err
);

  // Counter is wide enough to hold TIMEOUT itself, so it never wraps before the compare
  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t              r_state;
  state_t              w_nextState;
  logic                w_enterPulse;
  logic                w_clearPulse;
  logic [CNT_W-1:0]    r_waitCnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [1:0]          r_op;
  logic [RES_W-1:0]    r_result;

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_enterSync (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_enter),
    .pulse(w_enterPulse)
  );

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clearSync (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_clear),
    .pulse(w_clearPulse)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_GET_A;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; clear overrides every transition, and the unused code falls back to GET_A
  always_comb begin
    w_nextState = r_state;
    if (w_clearPulse) begin
      w_nextState = S_GET_A;
    end else begin
      case (r_state)
        S_GET_A:  if (w_enterPulse) w_nextState = S_GET_B;
        S_GET_B:  if (w_enterPulse) w_nextState = S_GET_OP;
        S_GET_OP: if (w_enterPulse) w_nextState = S_START;
        S_START:  w_nextState = S_WAIT;
        S_WAIT: begin
          if (alu_done) begin
            w_nextState = S_SHOW;
          end else if (r_waitCnt == CNT_MAX) begin
            w_nextState = S_ERR;
          end
        end
        S_SHOW:   if (w_enterPulse) w_nextState = S_GET_A;
        S_ERR:    w_nextState = S_ERR;
        default:  w_nextState = S_GET_A;
      endcase
    end
  end

  // Operand, opcode, result and timeout-counter registers, loaded according to the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_waitCnt <= '0;
    end else if (w_clearPulse) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_GET_A:  if (w_enterPulse) r_a <= sw;
        S_GET_B:  if (w_enterPulse) r_b <= sw;
        S_GET_OP: if (w_enterPulse) r_op <= sw[1:0];
        S_START:  r_waitCnt <= '0;
        S_WAIT: begin
          if (alu_done) begin
            r_result <= alu_result;
          end else if (r_waitCnt != CNT_MAX) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; the start pulse is suppressed when a clear arrives
  always_comb begin
    alu_start  = (r_state == S_START) && !w_clearPulse;
    err        = (r_state == S_ERR);
    state_out  = r_state;
    disp_value = r_result;
    case (r_state)
      S_GET_A, S_GET_B: disp_value = {{(RES_W-DATA_W){1'b0}}, sw};
      S_GET_OP:         disp_value = {{(RES_W-2){1'b0}}, sw[1:0]};
      S_ERR:            disp_value = RES_W'(ERR_DISP);
      default:          disp_value = r_result;
    endcase
  end

  assign a_reg      = r_a;
  assign b_reg      = r_b;
  assign op_reg     = r_op;
  assign result_reg = r_result;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer, built with a short timeout so
// the timeout and boundary cases stay quick to reach.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic [7:0]  sw;
  logic        btn_enter;
  logic        btn_clear;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        respDone;
  logic        manualDone;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [1:0]  op_reg;
  logic        alu_start;
  logic [15:0] result_reg;
  logic [15:0] disp_value;
  logic [2:0]  state_out;
  logic        err;

  int compared    = 0;
  int mismatched  = 0;
  int startCount  = 0;
  int respLatency = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    int          lat;
    logic [2:0]  expState;
    logic [15:0] expRes;
    int          expWait;
  } vec_t;

  vec_t vecs[6];

  assign alu_done = respDone | manualDone;

  calc_sequencer #(
    .DATA_W     (8),
    .RES_W      (16),
    .TIMEOUT    (TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clear (btn_clear),
    .alu_result(alu_result),
    .alu_done  (alu_done),
    .a_reg     (a_reg),
    .b_reg     (b_reg),
    .op_reg    (op_reg),
    .alu_start (alu_start),
    .result_reg(result_reg),
    .disp_value(disp_value),
    .state_out (state_out),
    .err       (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every cycle in which the start strobe is high
  always @(negedge clk) begin
    if (alu_start) startCount++;
  end

  // ALU stand-in: answers respLatency cycles into WAIT, or never when the latency is 0
  initial begin
    respDone = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start && respLatency != 0) begin
        repeat (respLatency) @(negedge clk);
        respDone = 1'b1;
        @(negedge clk);
        respDone = 1'b0;
      end
    end
  end

  function automatic logic [15:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
    case (op)
      OP_ADD:  return {8'h00, a} + {8'h00, b};
      OP_SUB:  return {8'h00, a} - {8'h00, b};
      OP_MUL:  return {8'h00, a} * {8'h00, b};
      OP_AND:  return {8'h00, a & b};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic enter, input logic clear, input logic [7:0] swVal,
                               input int cycles);
    btn_enter = enter;
    btn_clear = clear;
    sw        = swVal;
    repeat (cycles) tick();
  endtask

  task automatic enterValue(input logic [7:0] v, input logic [2:0] expNext);
    applyStimulus(1'b1, 1'b0, v, 3);
    checkOutput("enterState", {29'd0, state_out}, {29'd0, expNext});
    applyStimulus(1'b0, 1'b0, v, 3);
  endtask

  task automatic runCalc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input int lat, input logic [15:0] aluVal, input logic [2:0] expState,
                         input logic [15:0] expRes, input int expWait);
    logic [7:0] opSw;
    int         s0;
    int         waitCycles;
    logic       finished;
    opSw = {6'($urandom_range(0, 63)), op};
    applyStimulus(1'b0, 1'b0, a, 1);
    checkOutput("dispA", {16'd0, disp_value}, {24'd0, a});
    enterValue(a, 3'd1);
    enterValue(b, 3'd2);
    applyStimulus(1'b0, 1'b0, opSw, 1);
    checkOutput("dispOp", {16'd0, disp_value}, {30'd0, op});
    respLatency = lat;
    alu_result  = aluVal;
    s0          = startCount;
    applyStimulus(1'b1, 1'b0, opSw, 3);
    checkOutput("startState", {29'd0, state_out}, 32'd3);
    btn_enter  = 1'b0;
    waitCycles = 0;
    finished   = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) begin
      tick();
      if (state_out == 3'd4) waitCycles++;
      else if (state_out == 3'd5 || state_out == 3'd6) finished = 1'b1;
    end
    if (!finished) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL calcTimeout: got state %0d expected SHOW or ERR", state_out);
    end
    checkOutput("endState", {29'd0, state_out}, {29'd0, expState});
    checkOutput("waitCycles", waitCycles, expWait);
    checkOutput("startPulses", startCount - s0, 32'd1);
    checkOutput("aReg", {24'd0, a_reg}, {24'd0, a});
    checkOutput("bReg", {24'd0, b_reg}, {24'd0, b});
    checkOutput("opReg", {30'd0, op_reg}, {30'd0, op});
    if (expState == 3'd5) begin
      checkOutput("result", {16'd0, result_reg}, {16'd0, expRes});
      checkOutput("dispShow", {16'd0, disp_value}, {16'd0, expRes});
      checkOutput("errShow", {31'd0, err}, 32'd0);
      applyStimulus(1'b1, 1'b0, a, 3);
      checkOutput("showExit", {29'd0, state_out}, 32'd0);
      checkOutput("resultKept", {16'd0, result_reg}, {16'd0, expRes});
      checkOutput("aKept", {24'd0, a_reg}, {24'd0, a});
      applyStimulus(1'b0, 1'b0, a, 3);
    end else begin
      checkOutput("errFlag", {31'd0, err}, 32'd1);
      checkOutput("dispErr", {16'd0, disp_value}, 32'h0000EEEE);
      enterValue(a, 3'd6);
      applyStimulus(1'b0, 1'b1, a, 3);
      checkOutput("errClear", {29'd0, state_out}, 32'd0);
      checkOutput("clearResult", {16'd0, result_reg}, 32'd0);
      checkOutput("clearA", {24'd0, a_reg}, 32'd0);
      applyStimulus(1'b0, 1'b0, a, 3);
    end
  endtask

  // Main test sequence
  initial begin
    int         s0;
    int         transitions;
    int         firstAt;
    logic [2:0] prevState;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rop;
    int         rlat;
    logic [2:0] mState;
    int         mWait;

    vecs[0] = '{8'h0F, 8'h03, 2'd2, 5, 3'd5, 16'h002D, 5};
    vecs[1] = '{8'hFF, 8'h01, 2'd0, 1, 3'd5, 16'h0100, 1};
    vecs[2] = '{8'h05, 8'h07, 2'd1, 3, 3'd5, 16'hFFFE, 3};
    vecs[3] = '{8'hAA, 8'h0F, 2'd3, 2, 3'd5, 16'h000A, 2};
    vecs[4] = '{8'h12, 8'h34, 2'd2, 6, 3'd6, 16'h0000, TMO + 1};
    vecs[5] = '{8'h10, 8'h10, 2'd2, 0, 3'd6, 16'h0000, TMO + 1};

    manualDone = 1'b0;
    alu_result = 16'h0000;
    btn_enter  = 1'b0;
    btn_clear  = 1'b0;
    sw         = 8'h5A;
    reset      = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rstState", {29'd0, state_out}, 32'd0);
    checkOutput("rstA", {24'd0, a_reg}, 32'd0);
    checkOutput("rstResult", {16'd0, result_reg}, 32'd0);
    checkOutput("rstStart", {31'd0, alu_start}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstDisp", {16'd0, disp_value}, 32'h0000005A);
    applyStimulus(1'b0, 1'b0, 8'h5A, 2);

    $display("[TB] reset in the middle of WAIT");
    enterValue(8'h12, 3'd1);
    enterValue(8'h34, 3'd2);
    respLatency = 3;
    alu_result  = 16'h0999;
    applyStimulus(1'b1, 1'b0, 8'h02, 3);
    applyStimulus(1'b0, 1'b0, 8'h02, 1);
    checkOutput("preResetWait", {29'd0, state_out}, 32'd4);
    s0    = startCount;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h3C, 3);
    reset = 1'b0;
    checkOutput("midRstState", {29'd0, state_out}, 32'd0);
    checkOutput("midRstA", {24'd0, a_reg}, 32'd0);
    checkOutput("midRstB", {24'd0, b_reg}, 32'd0);
    checkOutput("midRstOp", {30'd0, op_reg}, 32'd0);
    checkOutput("midRstStart", startCount - s0, 32'd0);
    checkOutput("midRstDisp", {16'd0, disp_value}, 32'h0000003C);
    applyStimulus(1'b0, 1'b0, 8'h3C, 6);
    checkOutput("lateDoneResult", {16'd0, result_reg}, 32'd0);
    checkOutput("lateDoneState", {29'd0, state_out}, 32'd0);

    $display("[TB] held enter button");
    btn_enter   = 1'b1;
    sw          = 8'h21;
    transitions = 0;
    firstAt     = -1;
    prevState   = state_out;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (state_out != prevState) begin
        transitions++;
        if (firstAt < 0) firstAt = i + 1;
      end
      prevState = state_out;
    end
    checkOutput("holdLatency", firstAt, 32'd3);
    checkOutput("holdTransitions", transitions, 32'd1);
    checkOutput("holdState", {29'd0, state_out}, 32'd1);
    checkOutput("holdA", {24'd0, a_reg}, 32'h00000021);
    applyStimulus(1'b0, 1'b0, 8'h21, 3);

    $display("[TB] stray done outside WAIT");
    alu_result = 16'hBEEF;
    manualDone = 1'b1;
    tick();
    manualDone = 1'b0;
    tick();
    checkOutput("strayState", {29'd0, state_out}, 32'd1);
    checkOutput("strayResult", {16'd0, result_reg}, 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);
    checkOutput("strayClear", {29'd0, state_out}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 3);

    $display("[TB] enter and clear together in GET_OP");
    enterValue(8'h44, 3'd1);
    enterValue(8'h55, 3'd2);
    applyStimulus(1'b1, 1'b1, 8'h03, 3);
    checkOutput("bothState", {29'd0, state_out}, 32'd0);
    checkOutput("bothOp", {30'd0, op_reg}, 32'd0);
    checkOutput("bothA", {24'd0, a_reg}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 3);

    $display("[TB] clear during WAIT");
    enterValue(8'h66, 3'd1);
    enterValue(8'h02, 3'd2);
    respLatency = 5;
    alu_result  = 16'h00CC;
    applyStimulus(1'b1, 1'b0, 8'h00, 3);
    applyStimulus(1'b0, 1'b1, 8'h00, 3);
    checkOutput("waitClearState", {29'd0, state_out}, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 6);
    checkOutput("waitClearResult", {16'd0, result_reg}, 32'd0);
    checkOutput("waitClearIdle", {29'd0, state_out}, 32'd0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) begin
      runCalc(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat,
              aluModel(vecs[i].a, vecs[i].b, vecs[i].op),
              vecs[i].expState, vecs[i].expRes, vecs[i].expWait);
    end

    $display("[TB] randomized calculations");
    for (int i = 0; i < 16; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rop  = 2'($urandom_range(0, 3));
      rlat = $urandom_range(0, 7);
      if (rlat >= 1 && rlat <= TMO + 1) begin
        mState = 3'd5;
        mWait  = rlat;
      end else begin
        mState = 3'd6;
        mWait  = TMO + 1;
      end
      runCalc(ra, rb, rop, rlat, aluModel(ra, rb, rop), mState, aluModel(ra, rb, rop), mWait);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
